avmm_agent_mem: RTL and testbench
=================================

Name: avmm_agent_mem

Overview:
- Avalon-MM agent (responder) memory that serves the 64-bit read/write host port emitted by our HLS components, such as the avmm_0_rw port of the BLAS/LAPACK kernels.
- Provides word-addressed storage with a fixed, parameterised read latency, because the host port has no waitrequest or readdatavalid back-pressure.
- Includes a backdoor preload/peek port for test-bench initialisation and result checking.
- Used in component-level simulation systems and as an on-chip scratch memory.

Parameters:
- DEPTH, 1024, number of 64-bit words; power of two, 2..65536.
- READ_LATENCY, 1, cycles from read accept to readdata valid; legal 1..8.
- BASE_ADDR, 0, byte address of word 0; must be 8-byte aligned.

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- avmm_address  in  64  byte address from the host.
- avmm_byteenable  in  8  per-byte write enable.
- avmm_read  in  1  read request, accepted every cycle.
- avmm_readdata  out  64  read data.
- avmm_readdatavalid  out  1  high for exactly the cycle that readdata is valid.
- avmm_write  in  1  write request, accepted every cycle.
- avmm_writedata  in  64  write data.
- bd_wr  in  1  backdoor write of a full word.
- bd_addr  in  log2(DEPTH)  backdoor word index.
- bd_wdata  in  64  backdoor write data.
- bd_rdata  out  64  combinational peek of mem[bd_addr].
- oor_count  out  16  saturating count of out-of-range accesses.
- proto_err  out  1  sticky flag: read and write asserted in the same cycle.

Behaviour:
- Reset:
  - Clears avmm_readdata, avmm_readdatavalid, oor_count, proto_err and the read pipeline.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards every in-flight read; no readdatavalid appears after reset releases.
- Addressing:
  - off = avmm_address - BASE_ADDR, computed modulo 2^64.
  - Word index = off[63:3]; off[2:0] is ignored.
  - An access is in range when off[63:3] < DEPTH. An address below BASE_ADDR wraps to a large value and is therefore out of range.
- Write (avmm_write=1, in range):
  - On the next edge, byte b of mem[idx] takes avmm_writedata[8b+7:8b] for each b where avmm_byteenable[b]=1; other bytes are unchanged.
  - byteenable = 0x00 is a legal no-op.
- Read (avmm_read=1):
  - The index is sampled on the accepting edge.
  - avmm_readdata and avmm_readdatavalid present the result exactly READ_LATENCY edges later.
  - One read may be accepted per cycle, giving full throughput. The pipeline is a READ_LATENCY-deep shift register carrying {valid, data}.
  - Data is read from memory at accept time, so a later write cannot alter an in-flight read.
  - avmm_readdata holds its last value when readdatavalid is low.
- Out of range:
  - A write is dropped.
  - A read returns 0x0 with the normal latency and readdatavalid.
  - oor_count increments once per offending cycle and saturates at 0xFFFF.
- Simultaneous read and write from the host:
  - Both are performed.
  - The read returns the pre-write contents.
  - proto_err sets and holds until reset.
- Backdoor:
  - bd_wr writes the full word on the edge.
  - If bd_wr and a host write target the same word in the same cycle, the host write wins on the bytes it enables; bd_wdata supplies all other bytes.
  - bd_rdata reflects the current memory contents combinationally.

Optional Feature:
- Macro AVMM_AGENT_STATS_EN.
- When defined, add two outputs, rd_count[31:0] and wr_count[31:0]:
  - They count accepted host reads and host writes, in range or not.
  - Both wrap modulo 2^32 and clear on reset.
- When undefined, the ports still exist and are tied to 0, with no counter logic.

Test Plan:
1. READ_LATENCY=3, BASE_ADDR=0. Backdoor mem[5]=0x1122334455667788, then host read at address 0x28 -> readdatavalid exactly 3 cycles later with readdata 0x1122334455667788.
2. Host write address 0x8, data 0xAAAAAAAAAAAAAAAA, byteenable 0x0F, over an all-zero word -> bd_rdata at index 1 = 0x00000000AAAAAAAA.
3. Back-to-back reads of words 0..7 on consecutive cycles -> 8 consecutive readdatavalid cycles, in order, with no gaps.
4. BASE_ADDR=0x1000. Read at 0x0FF8 and write at 0x1000+8*DEPTH -> read returns 0, write is dropped, oor_count=2.
5. Same cycle: read and write to word 2 (old value 0x1, new value 0x2) -> read returns 0x1, proto_err=1, and a following read returns 0x2.
6. Issue a read, then assert reset for 1 cycle before its readdatavalid is due -> no readdatavalid after release, and all outputs are 0.

Source files
------------

// File: rtl/avmm_agent_mem.sv
// Avalon-MM responder memory: fixed read latency, byte-enabled writes, backdoor preload/peek port.
// Optional access counters are compiled in when AVMM_AGENT_STATS_EN is defined.
module avmm_agent_mem #(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [63:0] BASE_ADDR    = 64'h0,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [63:0]   avmm_address,
  input  logic [7:0]    avmm_byteenable,
  input  logic          avmm_read,
  output logic [63:0]   avmm_readdata,
  output logic          avmm_readdatavalid,
  input  logic          avmm_write,
  input  logic [63:0]   avmm_writedata,
  input  logic          bd_wr,
  input  logic [AW-1:0] bd_addr,
  input  logic [63:0]   bd_wdata,
  output logic [63:0]   bd_rdata,
  output logic [15:0]   oor_count,
  output logic          proto_err,
  output logic [31:0]   rd_count,
  output logic [31:0]   wr_count
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [63:0]   mem [DEPTH];
  logic [60:0]   off_word;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [63:0]   rd_word;
  logic          unused_addr_lsb;

  // BASE_ADDR is 8-byte aligned, so subtracting word parts equals off[63:3] of the byte subtraction.
  assign off_word        = avmm_address[63:3] - BASE_ADDR[63:3];
  assign in_range        = (off_word < 61'(DEPTH));
  assign idx             = off_word[AW-1:0];
  assign rd_word         = in_range ? mem[idx] : 64'h0;
  assign unused_addr_lsb = ^avmm_address[2:0];
  assign bd_rdata        = mem[bd_addr];

  // Host bytes are applied after the backdoor word so the host wins on the bytes it enables.
  always_ff @(posedge clock) begin
    if (bd_wr) mem[bd_addr] <= bd_wdata;
    if (avmm_write && in_range) begin
      for (int b = 0; b < 8; b++) begin
        if (avmm_byteenable[b]) mem[idx][8*b +: 8] <= avmm_writedata[8*b +: 8];
      end
    end
  end

  logic        rd_vld_p  [READ_LATENCY];
  logic [63:0] rd_data_p [READ_LATENCY];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        rd_vld_p[i]  <= 1'b0;
        rd_data_p[i] <= 64'h0;
      end
      oor_count <= 16'h0;
      proto_err <= 1'b0;
    end else begin
      // stage p0: memory sampled at accept; data only advances with valid so the output holds
      rd_vld_p[0] <= avmm_read;
      if (avmm_read) rd_data_p[0] <= rd_word;
      // stages p1..pN: plain shift toward the output
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        rd_vld_p[i] <= rd_vld_p[i-1];
        if (rd_vld_p[i-1]) rd_data_p[i] <= rd_data_p[i-1];
      end
      if ((avmm_read || avmm_write) && !in_range) oor_count <= sat_inc16(oor_count);
      if (avmm_read && avmm_write) proto_err <= 1'b1;
    end
  end

  assign avmm_readdatavalid = rd_vld_p[READ_LATENCY-1];
  assign avmm_readdata      = rd_data_p[READ_LATENCY-1];

`ifdef AVMM_AGENT_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      if (avmm_read)  rd_cnt_q <= rd_cnt_q + 32'd1;
      if (avmm_write) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = 32'h0;
  assign wr_count = 32'h0;
`endif

endmodule

// File: tb/tb_avmm_agent_mem.sv
// Randomized bench for avmm_agent_mem against a queue/array reference model of the memory and read returns.
module tb_avmm_agent_mem;
  localparam int          DEPTH = 64;
  localparam int          LAT   = 3;
  localparam logic [63:0] BASE  = 64'h1000;

  logic        clock, reset;
  logic [63:0] avmm_address, avmm_writedata, avmm_readdata, bd_wdata, bd_rdata;
  logic [7:0]  avmm_byteenable;
  logic        avmm_read, avmm_write, avmm_readdatavalid, bd_wr, proto_err;
  logic [5:0]  bd_addr;
  logic [15:0] oor_count;
  logic [31:0] rd_count, wr_count;

  avmm_agent_mem #(.DEPTH(DEPTH), .READ_LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset),
    .avmm_address(avmm_address), .avmm_byteenable(avmm_byteenable),
    .avmm_read(avmm_read), .avmm_readdata(avmm_readdata),
    .avmm_readdatavalid(avmm_readdatavalid),
    .avmm_write(avmm_write), .avmm_writedata(avmm_writedata),
    .bd_wr(bd_wr), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata),
    .oor_count(oor_count), .proto_err(proto_err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic [63:0] d;
  } rd_t;

  logic [63:0] mm [DEPTH];
  rd_t         rq[$];
  int          cyc = 0;
  logic [63:0] last_d = 64'h0;
  int          m_oor = 0;
  bit          m_proto = 0;
  int unsigned m_rd = 0, m_wr = 0;

  task automatic idle();
    avmm_read = 0; avmm_write = 0; bd_wr = 0; avmm_byteenable = 8'h00;
  endtask

  // Apply the current inputs for one clock, update the model, then check every output.
  task automatic step();
    logic [63:0] off;
    logic [60:0] w;
    bit          inr, exp_v;
    int          idx;
    rd_t         e;
    off = avmm_address - BASE;
    w   = off[63:3];
    inr = (w < 61'(DEPTH));
    idx = inr ? int'(w) : 0;
    if (avmm_read) begin
      e.due = cyc + LAT;
      e.d   = inr ? mm[idx] : 64'h0;
      rq.push_back(e);
      m_rd++;
    end
    if (bd_wr) mm[bd_addr] = bd_wdata;
    if (avmm_write) begin
      m_wr++;
      if (inr)
        for (int b = 0; b < 8; b++)
          if (avmm_byteenable[b]) mm[idx][8*b +: 8] = avmm_writedata[8*b +: 8];
    end
    if ((avmm_read || avmm_write) && !inr && m_oor < 65535) m_oor++;
    if (avmm_read && avmm_write) m_proto = 1;
    @(posedge clock);
    cyc++;
    #1;
    exp_v = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_v  = 1;
      last_d = rq[0].d;
      void'(rq.pop_front());
    end
    chk("readdatavalid", 64'(avmm_readdatavalid), 64'(exp_v));
    chk("readdata", avmm_readdata, last_d);
    chk("oor_count", 64'(oor_count), 64'(m_oor));
    chk("proto_err", 64'(proto_err), 64'(m_proto));
    chk("bd_rdata", bd_rdata, mm[bd_addr]);
`ifdef AVMM_AGENT_STATS_EN
    chk("rd_count", 64'(rd_count), 64'(m_rd));
    chk("wr_count", 64'(wr_count), 64'(m_wr));
`else
    chk("rd_count", 64'(rd_count), 64'h0);
    chk("wr_count", 64'(wr_count), 64'h0);
`endif
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    @(posedge clock);
    cyc++;
    #1;
    reset = 0;
    rq.delete();
    last_d = 64'h0; m_oor = 0; m_proto = 0; m_rd = 0; m_wr = 0;
    chk("rst_readdatavalid", 64'(avmm_readdatavalid), 64'h0);
    chk("rst_readdata", avmm_readdata, 64'h0);
    chk("rst_oor_count", 64'(oor_count), 64'h0);
    chk("rst_proto_err", 64'(proto_err), 64'h0);
  endtask

  task automatic bd_write(input int i, input logic [63:0] d);
    idle();
    bd_addr = 6'(i); bd_wdata = d; bd_wr = 1;
    step();
    bd_wr = 0;
  endtask

  function automatic logic [63:0] rand_addr();
    int k;
    logic [63:0] a;
    k = $urandom_range(0, 9);
    if (k < 8)       a = BASE + 64'($urandom_range(0, DEPTH-1)) * 8 + 64'($urandom_range(0, 7));
    else if (k == 8) a = BASE + 64'(DEPTH + $urandom_range(0, 3)) * 8;
    else             a = BASE - 64'($urandom_range(1, 16));
    return a;
  endfunction

  task automatic random_phase(input int n, input bit allow_both);
    for (int c = 0; c < n; c++) begin
      idle();
      avmm_address    = rand_addr();
      avmm_read       = ($urandom_range(0, 1) == 1);
      avmm_write      = ($urandom_range(0, 2) == 0);
      if (!allow_both && avmm_read) avmm_write = 0;
      avmm_byteenable = 8'($urandom);
      avmm_writedata  = {$urandom, $urandom};
      bd_addr         = 6'($urandom_range(0, DEPTH-1));
      bd_wdata        = {$urandom, $urandom};
      bd_wr           = ($urandom_range(0, 4) == 0);
      step();
    end
    idle();
    for (int c = 0; c < LAT + 1; c++) step();
  endtask

  initial begin
    idle();
    reset = 1;
    avmm_address = 64'h0; avmm_writedata = 64'h0; bd_addr = 6'h0; bd_wdata = 64'h0;
    #2;
    do_reset();
    for (int i = 0; i < DEPTH; i++) bd_write(i, {$urandom, $urandom});

    // Read latency: backdoor word 5 then host read
    bd_write(5, 64'h1122334455667788);
    avmm_address = BASE + 64'h28; avmm_read = 1;
    step();
    idle();
    step(); step();
    chk("lat_valid", 64'(avmm_readdatavalid), 64'h1);
    chk("lat_data", avmm_readdata, 64'h1122334455667788);
    step();
    chk("lat_hold", avmm_readdata, 64'h1122334455667788);

    // Partial write over a zero word
    bd_write(1, 64'h0);
    avmm_address = BASE + 64'h8; avmm_writedata = 64'hAAAAAAAAAAAAAAAA;
    avmm_byteenable = 8'h0F; avmm_write = 1; bd_addr = 6'd1;
    step();
    idle();
    chk("be_write", bd_rdata, 64'h00000000AAAAAAAA);

    // Back-to-back reads of words 0..7
    for (int i = 0; i < 8; i++) begin
      avmm_address = BASE + 64'(i) * 8; avmm_read = 1;
      step();
    end
    idle();
    for (int i = 0; i < LAT + 1; i++) step();

    // Out-of-range read and write
    do_reset();
    bd_addr = 6'd0;
    avmm_address = BASE - 64'h8; avmm_read = 1;
    step();
    idle();
    avmm_address = BASE + 64'(DEPTH) * 8; avmm_writedata = 64'hDEADBEEFDEADBEEF;
    avmm_byteenable = 8'hFF; avmm_write = 1;
    step();
    idle();
    step();
    chk("oor_rdata", avmm_readdata, 64'h0);
    chk("oor_count2", 64'(oor_count), 64'h2);

    // Simultaneous read and write to word 2
    bd_write(2, 64'h1);
    avmm_address = BASE + 64'h10; avmm_read = 1; avmm_write = 1;
    avmm_writedata = 64'h2; avmm_byteenable = 8'hFF;
    step();
    idle();
    avmm_address = BASE + 64'h10; avmm_read = 1;
    step();
    idle();
    step();
    chk("rw_old", avmm_readdata, 64'h1);
    chk("rw_proto", 64'(proto_err), 64'h1);
    step();
    chk("rw_new", avmm_readdata, 64'h2);

    // Reset while a read is in flight
    avmm_address = BASE + 64'h28; avmm_read = 1;
    step();
    do_reset();
    for (int i = 0; i < LAT + 2; i++) step();

    random_phase(300, 1'b0);
    do_reset();
    random_phase(300, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
